// File: rtl/opcode_dispatcher_pkg.sv
// Shared opcode encodings, dispatcher state type and opcode classification
// for the motion opcode dispatcher.
package opcode_dispatcher_pkg;

    localparam int OPCODE_BITS = 3;

    localparam logic [OPCODE_BITS-1:0] OP_G00 = 3'd0;
    localparam logic [OPCODE_BITS-1:0] OP_G01 = 3'd1;
    localparam logic [OPCODE_BITS-1:0] OP_G02 = 3'd2;
    localparam logic [OPCODE_BITS-1:0] OP_G03 = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        TRIGGER,
        WAIT_DONE,
        COOLDOWN,
        ERROR
    } dispatcher_state_t;

    // Only the contiguous G00..G03 block is handled downstream.
    function automatic logic is_supported_op(input logic [31:0] op);
        return op <= 32'(OP_G03);
    endfunction

endpackage

// File: rtl/opcode_dispatcher_dispatch_counter.sv
// Loadable down-counter with terminal-count flags; shared between the
// done watchdog and the post-operation settle gap.
module dispatch_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             tc,
    output logic             tc_next
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_value;
        end else if (en && (count_reg != '0)) begin
            count_next = count_reg - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // tc_next lets the owner register outputs that depend on the count value
    // the counter will hold in the coming cycle.
    assign tc      = (count_reg == '0);
    assign tc_next = (count_next == '0);

endmodule

// File: rtl/opcode_dispatcher.sv
// Sequences one motion opcode at a time into the processor selector:
// accept, single-cycle trigger, wait for done (watchdogged), settle gap.
module opcode_dispatcher
    import opcode_dispatcher_pkg::*;
#(
    parameter int OP_BITS        = OPCODE_BITS,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int GAP_CYCLES     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_BITS-1:0] op_in,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic               abort,
    input  logic               clear_err,
    input  logic               done_in,
    output logic [OP_BITS-1:0] op_out,
    output logic               trigger_out,
    output logic               busy,
    output logic               op_done,
    output logic               err_unsupported,
    output logic               err_timeout
);

    localparam int MAX_COUNT = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);
    localparam bit WDOG_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   WDOG_LOAD = WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [OP_BITS-1:0] RESET_OP  = OP_BITS'(OP_G00);

    dispatcher_state_t state_reg, state_next;
    logic [OP_BITS-1:0] op_out_reg, op_out_next;
    logic trigger_reg, trigger_next;
    logic busy_reg, busy_next;
    logic op_done_reg, op_done_next;
    logic err_unsup_reg, err_unsup_next;
    logic err_timeout_reg, err_timeout_next;
    logic suppress_reg, suppress_next;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_value;
    logic             cnt_en;
    logic             cnt_tc;
    logic             cnt_tc_next;
    logic             op_supported;

    assign op_supported = is_supported_op(32'(op_in));

    dispatch_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .en         (cnt_en),
        .tc         (cnt_tc),
        .tc_next    (cnt_tc_next)
    );

    always_comb begin
        state_next       = state_reg;
        op_out_next      = op_out_reg;
        suppress_next    = suppress_reg;
        err_unsup_next   = 1'b0;
        err_timeout_next = err_timeout_reg && !clear_err;
        cnt_load         = 1'b0;
        cnt_load_value   = GAP_LOAD;
        cnt_en           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (op_valid && !abort) begin
                    if (op_supported) begin
                        op_out_next   = op_in;
                        suppress_next = 1'b0;
                        state_next    = TRIGGER;
                    end else begin
                        err_unsup_next = 1'b1;
                    end
                end
            end
            TRIGGER: begin
                if (abort) begin
                    state_next    = COOLDOWN;
                    cnt_load      = 1'b1;
                    suppress_next = 1'b1;
                end else begin
                    state_next     = WAIT_DONE;
                    cnt_load       = 1'b1;
                    cnt_load_value = WDOG_LOAD;
                end
            end
            WAIT_DONE: begin
                // Abort beats done, done beats timeout.
                if (abort) begin
                    state_next    = COOLDOWN;
                    cnt_load      = 1'b1;
                    suppress_next = 1'b1;
                end else if (done_in) begin
                    state_next = COOLDOWN;
                    cnt_load   = 1'b1;
                end else if (WDOG_EN && cnt_tc) begin
                    state_next       = ERROR;
                    err_timeout_next = 1'b1;
                end else begin
                    cnt_en = WDOG_EN;
                end
            end
            COOLDOWN: begin
                if (abort) begin
                    cnt_load      = 1'b1;
                    suppress_next = 1'b1;
                end else if (cnt_tc) begin
                    state_next = IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ERROR: begin
                if (clear_err) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The last gap cycle already reports completion: busy falls with op_done.
    always_comb begin
        trigger_next = (state_next == TRIGGER);
        busy_next    = (state_next inside {TRIGGER, WAIT_DONE, ERROR}) ||
                       ((state_next == COOLDOWN) && !cnt_tc_next);
        op_done_next = (state_next == COOLDOWN) && cnt_tc_next && !suppress_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            op_out_reg      <= RESET_OP;
            trigger_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            op_done_reg     <= 1'b0;
            err_unsup_reg   <= 1'b0;
            err_timeout_reg <= 1'b0;
            suppress_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            op_out_reg      <= op_out_next;
            trigger_reg     <= trigger_next;
            busy_reg        <= busy_next;
            op_done_reg     <= op_done_next;
            err_unsup_reg   <= err_unsup_next;
            err_timeout_reg <= err_timeout_next;
            suppress_reg    <= suppress_next;
        end
    end

    assign op_ready        = (state_reg == IDLE) && !abort && !reset;
    assign op_out          = op_out_reg;
    assign trigger_out     = trigger_reg;
    assign busy            = busy_reg;
    assign op_done         = op_done_reg;
    assign err_unsupported = err_unsup_reg;
    assign err_timeout     = err_timeout_reg;

endmodule

// File: tb/tb_opcode_dispatcher.sv
// Bench for opcode_dispatcher: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_opcode_dispatcher;

    localparam int OPW = 3;
    localparam int TMO = 20;
    localparam int GAP = 4;

    localparam int PH_IDLE = 0;
    localparam int PH_TRIG = 1;
    localparam int PH_WAIT = 2;
    localparam int PH_COOL = 3;
    localparam int PH_ERR  = 4;

    logic           clk;
    logic           reset;
    logic [OPW-1:0] op_in;
    logic           op_valid;
    logic           op_ready;
    logic           abort;
    logic           clear_err;
    logic           done_in;
    logic [OPW-1:0] op_out;
    logic           trigger_out;
    logic           busy;
    logic           op_done;
    logic           err_unsupported;
    logic           err_timeout;

    int checks = 0;
    int errors = 0;

    // model state
    int m_ph;
    int m_op;
    int m_waited;
    int m_gap_left;
    bit m_aborted;
    bit e_unsup;
    bit e_tout;

    opcode_dispatcher #(
        .OP_BITS        (OPW),
        .TIMEOUT_CYCLES (TMO),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .op_in           (op_in),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .abort           (abort),
        .clear_err       (clear_err),
        .done_in         (done_in),
        .op_out          (op_out),
        .trigger_out     (trigger_out),
        .busy            (busy),
        .op_done         (op_done),
        .err_unsupported (err_unsupported),
        .err_timeout     (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ph = PH_IDLE; m_op = 0; m_waited = 0; m_gap_left = 0;
        m_aborted = 0; e_unsup = 0; e_tout = 0;
    endtask

    task automatic m_start_gap(input bit by_abort);
        m_ph = PH_COOL;
        m_gap_left = GAP;
        if (by_abort) m_aborted = 1;
    endtask

    task automatic m_step();
        e_unsup = 0;
        if (clear_err) e_tout = 0;
        case (m_ph)
            PH_IDLE: if (op_valid && !abort) begin
                if (int'(op_in) <= 3) begin
                    m_op = int'(op_in); m_ph = PH_TRIG; m_aborted = 0;
                end else begin
                    e_unsup = 1;
                end
            end
            PH_TRIG: if (abort) m_start_gap(1); else begin m_ph = PH_WAIT; m_waited = 0; end
            PH_WAIT: begin
                if (abort) m_start_gap(1);
                else if (done_in) m_start_gap(0);
                else if (m_waited == TMO - 1) begin m_ph = PH_ERR; e_tout = 1; end
                else m_waited++;
            end
            PH_COOL: begin
                if (abort) m_start_gap(1);
                else if (m_gap_left == 1) m_ph = PH_IDLE;
                else m_gap_left--;
            end
            default: if (clear_err) m_ph = PH_IDLE;
        endcase
    endtask

    // Single compare process: registered outputs checked mid-cycle, then the
    // model advances on this cycle's inputs.
    always @(negedge clk) begin
        if (reset) m_reset();
        check("op_ready", 32'(op_ready), 32'((m_ph == PH_IDLE) && !abort && !reset));
        check("trigger_out", 32'(trigger_out), 32'(m_ph == PH_TRIG));
        check("busy", 32'(busy), 32'((m_ph == PH_TRIG) || (m_ph == PH_WAIT) || (m_ph == PH_ERR) ||
                                     ((m_ph == PH_COOL) && (m_gap_left > 1))));
        check("op_done", 32'(op_done), 32'((m_ph == PH_COOL) && (m_gap_left == 1) && !m_aborted));
        check("err_unsupported", 32'(err_unsupported), 32'(e_unsup));
        check("err_timeout", 32'(err_timeout), 32'(e_tout));
        check("op_out", 32'(op_out), 32'(m_op));
        if (!reset) m_step();
    end

    task step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!op_ready && n < 60) begin step(); n++; end
        check(name, 32'(op_ready), 32'd1);
    endtask

    task automatic send_op(input logic [OPW-1:0] op);
        wait_ready("send_ready");
        op_valid = 1'b1;
        op_in = op;
        step();
        op_valid = 1'b0;
        op_in = 3'($urandom_range(0, 7));
    endtask

    task automatic finish_op();
        repeat (2) step();
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        wait_ready("finish_ready");
    endtask

    task automatic abort_window(input string name);
        int n = 1;
        bit saw_done = 0;
        while (!op_ready && n < 30) begin
            saw_done |= op_done;
            step();
            n++;
        end
        check({name, "_no_op_done"}, 32'(saw_done), 32'd0);
        check({name, "_gap"}, 32'(n), 32'(GAP + 1));
    endtask

    initial begin
        int n;
        logic [OPW-1:0] bad_ops [3];
        bad_ops[0] = 3'd5; bad_ops[1] = 3'd6; bad_ops[2] = 3'd7;

        reset = 1'b1; op_valid = 1'b1; op_in = 3'd1;
        abort = 1'b0; clear_err = 1'b0; done_in = 1'b0;
        #1;
        check("lit_ready_in_reset", 32'(op_ready), 32'd0);
        repeat (3) step();
        check("lit_busy_in_reset", 32'(busy), 32'd0);
        reset = 1'b0; op_valid = 1'b0;
        #1;
        check("lit_ready_after_reset", 32'(op_ready), 32'd1);

        // normal G01, done 10 cycles after trigger
        send_op(3'd1);
        check("lit_trigger_after_accept", 32'(trigger_out), 32'd1);
        check("lit_op_out_g01", 32'(op_out), 32'd1);
        check("lit_ready_low_after_accept", 32'(op_ready), 32'd0);
        step();
        check("lit_trigger_single", 32'(trigger_out), 32'd0);
        repeat (9) step();
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        n = 1;
        while (!op_done && n < 20) begin step(); n++; end
        check("lit_done_latency", 32'(n), 32'(GAP));
        check("lit_busy_at_done", 32'(busy), 32'd0);
        check("lit_ready_at_done", 32'(op_ready), 32'd0);
        check("lit_op_out_held", 32'(op_out), 32'd1);
        step();
        check("lit_ready_after_done", 32'(op_ready), 32'd1);

        // three bad opcodes back to back, then G02
        op_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op_in = bad_ops[i];
            step();
            check("lit_unsup_pulse", 32'(err_unsupported), 32'd1);
            check("lit_unsup_no_trigger", 32'(trigger_out), 32'd0);
        end
        op_in = 3'd2;
        step();
        op_valid = 1'b0;
        check("lit_unsup_clear", 32'(err_unsupported), 32'd0);
        check("lit_g02_trigger", 32'(trigger_out), 32'd1);
        check("lit_g02_op_out", 32'(op_out), 32'd2);
        finish_op();

        // watchdog timeout
        send_op(3'd0);
        step();
        n = 0;
        while (!err_timeout && n < 40) begin step(); n++; end
        check("lit_timeout_cycles", 32'(n), 32'(TMO));
        check("lit_timeout_ready", 32'(op_ready), 32'd0);
        check("lit_timeout_busy", 32'(busy), 32'd1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("lit_clear_err", 32'(err_timeout), 32'd0);
        check("lit_clear_ready", 32'(op_ready), 32'd1);
        send_op(3'd1);
        check("lit_after_clear_trigger", 32'(trigger_out), 32'd1);
        finish_op();

        // abort 5 cycles into WAIT_DONE
        send_op(3'd3);
        repeat (6) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        abort_window("lit_abort");

        // abort together with done
        send_op(3'd3);
        repeat (3) step();
        abort = 1'b1; done_in = 1'b1;
        step();
        abort = 1'b0; done_in = 1'b0;
        abort_window("lit_abort_done");

        // reset during TRIGGER and during WAIT_DONE
        for (int k = 0; k < 2; k++) begin
            send_op(3'd2);
            repeat (k * 3) step();
            reset = 1'b1;
            #1;
            check("lit_async_trigger", 32'(trigger_out), 32'd0);
            check("lit_async_busy", 32'(busy), 32'd0);
            step();
            reset = 1'b0;
            #1;
            check("lit_idle_after_reset", 32'(op_ready), 32'd1);
        end

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            op_valid  = ($urandom_range(0, 9) < 3);
            op_in     = 3'($urandom_range(0, 7));
            abort     = ($urandom_range(0, 99) < 3);
            done_in   = ($urandom_range(0, 99) < 8);
            clear_err = ($urandom_range(0, 99) < 4);
            reset     = ($urandom_range(0, 599) == 0);
            step();
        end
        reset = 1'b0; op_valid = 1'b0; abort = 1'b0; done_in = 1'b0; clear_err = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/opcode_dispatcher.md
Name: opcode_dispatcher

Overview:
- Sequences one motion opcode at a time from the opcode fetch stage into the processor selector and its linear and circular handlers.
- Accepts an opcode over a valid/ready handshake and holds the selector's op input stable for the whole operation.
- Issues a single-cycle trigger, waits for the routed done, and enforces a settle gap before accepting the next opcode.
- Rejects unsupported opcodes and aborts stalled operations through a watchdog.

Parameters:
- OP_BITS, `OP_BITS: width of the op field.
- TIMEOUT_CYCLES, 50_000_000: max cycles in WAIT_DONE before a timeout; 0 disables the watchdog.
- GAP_CYCLES, 4: cycles op_out is held after done before returning to IDLE; minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- op_in  in  OP_BITS  opcode from the fetch stage.
- op_valid  in  1  op_in is valid.
- op_ready  out  1  dispatcher accepts op_in this cycle.
- abort  in  1  cancel the current operation.
- clear_err  in  1  leave the ERROR state and clear sticky flags.
- done_in  in  1  done_out from the processor selector.
- op_out  out  OP_BITS  op driven to the processor selector.
- trigger_out  out  1  trigger_in of the processor selector.
- busy  out  1  an operation is in flight.
- op_done  out  1  one-cycle pulse on normal completion.
- err_unsupported  out  1  one-cycle pulse when an opcode is rejected.
- err_timeout  out  1  sticky watchdog timeout flag.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; op_out=OP_G00 encoding; trigger_out=0; busy=0; op_done=0; err_unsupported=0; err_timeout=0; counters=0. Reset asserted mid-operation drops trigger immediately; the handlers are reset by the same reset.
- All outputs are registered except op_ready, which is combinational: op_ready = (state==IDLE) && !abort.
- Supported opcodes are OP_G00 to OP_G03. Every other encoding is unsupported.
- IDLE: on op_valid && op_ready, the transfer completes.
  - Supported op: latch it into op_out, go to TRIGGER, set busy=1 next cycle.
  - Unsupported op: op_out is unchanged, err_unsupported pulses next cycle, state stays IDLE. Back-to-back bad ops pulse on consecutive cycles.
- TRIGGER: trigger_out=1 for exactly this one cycle; op_out has been stable for at least 1 cycle. done_in is ignored. Next state is WAIT_DONE.
- WAIT_DONE: watchdog counter increments each cycle.
  - done_in=1: go to COOLDOWN and clear the counter.
  - Counter reaches TIMEOUT_CYCLES-1 without done (TIMEOUT_CYCLES≠0): go to ERROR, set err_timeout=1.
  - done_in and timeout in the same cycle: done wins.
  - Trigger-to-done latency is unbounded except by the watchdog.
- COOLDOWN: op_out held for GAP_CYCLES cycles. On the last cycle, op_done pulses and the state goes to IDLE (busy=0 the same cycle op_done=1). Minimum opcode-to-opcode spacing is therefore 1 (accept) + 1 (trigger) + ≥1 (wait) + GAP_CYCLES.
- abort:
  - In TRIGGER, WAIT_DONE or COOLDOWN: go to COOLDOWN with the counter reloaded. The gap still applies so the handler's done can settle. op_done is NOT pulsed on the abort path; a flag suppresses it.
  - abort in the same cycle as done_in: treated as abort.
- ERROR: busy=1, op_ready=0, trigger_out=0. Leaves only on clear_err, going to IDLE and clearing err_timeout. clear_err in other states only clears err_timeout.
- Counter width: $clog2(max(TIMEOUT_CYCLES, GAP_CYCLES)+1). A single shared counter is used, since the states are exclusive.
- op_in changes while not accepted are ignored. op_out never changes outside the IDLE accept cycle.

Decomposition:
- Opcode_p: add an is_supported_op(op) function returning 1 for OP_G00..OP_G03. Opcode encodings stay in Opcode_p.
- Processor_p (new package included through processor.svh): DispatcherState_t enum {IDLE, TRIGGER, WAIT_DONE, COOLDOWN, ERROR}.
- One sub-module, dispatch_counter: loadable down-counter with a terminal-count flag, used for both the watchdog and the gap.

Test Plan:
- Reset: hold reset 3 cycles with op_valid=1 → all outputs 0, op_ready=0 during reset and 1 the cycle after release.
- Normal op: send G01 (op_valid 1 cycle); done_in rises 10 cycles after trigger, GAP_CYCLES=4 → trigger_out high exactly 1 cycle after accept; op_done pulses 4 cycles after done; op_ready is low from accept to the op_done cycle; op_out=G01 throughout.
- Unsupported op: send 3 consecutive invalid encodings, then G02 → err_unsupported pulses 3 consecutive cycles, no trigger; G02 is then triggered normally.
- Timeout: TIMEOUT_CYCLES=20, send G00, never assert done → err_timeout=1 at cycle 20 after entering WAIT_DONE, op_ready stays 0; pulse clear_err → IDLE, err_timeout=0, next op is accepted.
- Abort: send G03, assert abort 5 cycles into WAIT_DONE → no op_done, returns to IDLE after GAP_CYCLES; abort and done in the same cycle → no op_done.
- Reset mid-operation: assert reset during WAIT_DONE → trigger_out and busy drop asynchronously in the same cycle; state is IDLE after release.
